// File: rtl/pipeline_stall_control.sv
// rtl/pipeline_stall_control.sv - prioritised stall vector and multi-cycle EX countdown for the 5-stage pipeline
// Optional stall-cycle performance counter: define STALL_CONTROL_PERF_COUNTER_EN.
module pipeline_stall_control #(
  parameter int CYCLE_WIDTH = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   id_stall_request,
  input  logic                   ex_stall_request,
  input  logic                   ex_multicycle_start,
  input  logic [CYCLE_WIDTH-1:0] ex_multicycle_cycles,
  input  logic                   mem_stall_request,
`ifdef STALL_CONTROL_PERF_COUNTER_EN
  output logic [31:0]            stall_cycle_count,
`endif
  output logic [5:0]             stall,
  output logic                   ex_multicycle_busy,
  output logic                   ex_multicycle_done
);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [CYCLE_WIDTH-1:0] count, count_next;
  logic                   long_start;
  logic                   ex_hold;

  // Lengths 0 and 1 complete in the start cycle and never touch the FSM.
  assign long_start = (state == IDLE) && ex_multicycle_start &&
                      (ex_multicycle_cycles >= CYCLE_WIDTH'(2));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    if (flush) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (long_start) begin
            state_next = BUSY;
            count_next = ex_multicycle_cycles - CYCLE_WIDTH'(1);
          end
        end
        BUSY: begin
          if (count == CYCLE_WIDTH'(1)) begin
            state_next = DONE;
            count_next = '0;
          end else begin
            count_next = count - CYCLE_WIDTH'(1);
          end
        end
        DONE: begin
          if (!mem_stall_request) state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  assign ex_hold = ex_stall_request || long_start || (state == BUSY);

  // Reset masks the outputs combinationally so they drop without waiting for an edge.
  always_comb begin
    stall = STALL_NONE;
    if (reset || flush)          stall = STALL_NONE;
    else if (mem_stall_request)  stall = STALL_MEM;
    else if (ex_hold)            stall = STALL_EX;
    else if (id_stall_request)   stall = STALL_ID;
  end

  assign ex_multicycle_busy = !reset && (state == BUSY);
  assign ex_multicycle_done = !reset && (state == DONE);

`ifdef STALL_CONTROL_PERF_COUNTER_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycle_count <= '0;
    end else if (stall[0] && !flush && (stall_cycle_count != 32'hFFFF_FFFF)) begin
      stall_cycle_count <= stall_cycle_count + 32'd1;
    end
  end
`endif

endmodule
